// File: rtl/axi_read_arbiter_if.sv
// axi_read_arbiter_if: AXI3 read address/data channel bundle between the read arbiter and the bus
interface axi_read_arbiter_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        input  arready, rid, rdata, rresp, rlast, rvalid
    );
    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid, rready,
        output arready, rid, rdata, rresp, rlast, rvalid
    );
endinterface

// File: rtl/axi_read_arbiter.sv
// axi_read_arbiter: single-outstanding, single-beat AXI3 read arbiter; loads win over fetches, with a starvation guard
module axi_read_arbiter #(
    parameter logic [3:0] INST_ID      = 4'h0,
    parameter logic [3:0] DATA_ID      = 4'h1,
    parameter int         STARVE_LIMIT = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      inst_req,
    input  logic [31:0]               inst_addr,
    output logic                      inst_gnt,
    output logic                      inst_rvalid,
    output logic [31:0]               inst_rdata,
    input  logic                      data_req,
    input  logic [31:0]               data_addr,
    input  logic [1:0]                data_size,
    output logic                      data_gnt,
    output logic                      data_rvalid,
    output logic [31:0]               data_rdata,
    output logic                      rd_err,
    output logic                      busy,
    axi_read_arbiter_if.master        axi
);
    localparam logic [1:0] S_IDLE = 2'd0, S_AR = 2'd1, S_R = 2'd2;
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);
    logic [1:0]    state;
    logic [CW-1:0] starve_cnt;
    logic          owner_data;
    logic [31:0]   rdata_q;
    logic          idle, done, unused_rid;
    assign idle        = state == S_IDLE;
    assign inst_gnt    = idle && inst_req && (!data_req || starve_cnt == LIMIT);
    assign data_gnt    = idle && data_req && !inst_gnt;
    assign done        = state == S_R && axi.rvalid && axi.rlast;
    assign busy        = !idle;
    assign axi.arvalid = state == S_AR;
    assign axi.rready  = state == S_R;
    assign axi.arlen   = 4'd0;
    assign axi.arburst = 2'b01;
    assign axi.arlock  = 2'b00;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign inst_rdata  = rdata_q;
    assign data_rdata  = rdata_q;
    assign unused_rid  = ^axi.rid;
    always_ff @(posedge aclk or negedge aresetn)
        if (!aresetn) begin
            state       <= S_IDLE;
            starve_cnt  <= '0;
            owner_data  <= 1'b0;
            rdata_q     <= '0;
            inst_rvalid <= 1'b0;
            data_rvalid <= 1'b0;
            rd_err      <= 1'b0;
            axi.araddr  <= '0;
            axi.arid    <= '0;
            axi.arsize  <= '0;
        end else begin
            inst_rvalid <= done && !owner_data;
            data_rvalid <= done && owner_data;
            rd_err      <= done && axi.rresp != 2'b00;
            if (done) rdata_q <= axi.rdata;
            // Count only data wins that passed over a waiting fetch; any idle cycle without a fetch request restarts the count
            if (idle) starve_cnt <= inst_gnt || !inst_req ? '0 :
                                    data_gnt && starve_cnt != LIMIT ? starve_cnt + 1'b1 : starve_cnt;
            if (inst_gnt || data_gnt) begin
                axi.araddr <= inst_gnt ? inst_addr : data_addr;
                axi.arid   <= inst_gnt ? INST_ID : DATA_ID;
                axi.arsize <= inst_gnt ? 3'b010 : {1'b0, data_size};
                owner_data <= data_gnt;
            end
            state <= inst_gnt || data_gnt ? S_AR :
                     state == S_AR && axi.arready ? S_R :
                     done ? S_IDLE : state;
        end
endmodule
